// File: rtl/dtc_vote_window.sv
// Windowed majority vote over 2-bit classifier labels; emits argmax class, count and tie flag.
// Optional early window end via the flush input when DTC_VOTE_FLUSH_EN is defined.
module dtc_vote_window #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_class,
    output logic [CNT_W-1:0] out_count,
    output logic             out_tie
`ifdef DTC_VOTE_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    typedef enum logic {ACCUM, EMIT} state_t;

    localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [CNT_W-1:0] n_samp_q, n_samp_d;
    logic             in_ready_q, out_valid_q, out_tie_q;
    logic [1:0]       out_class_q;
    logic [CNT_W-1:0] out_count_q;

    logic             accept, flush_w, done;
    logic [1:0]       best_cls;
    logic [CNT_W-1:0] best_cnt;
    logic             best_tie;

`ifdef DTC_VOTE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign accept = in_valid && (state_q == ACCUM);

    // Next counts include the sample accepted this cycle so the decision sees it.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && (in_class == 2'(i)))
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        n_samp_d = n_samp_q + CNT_W'(accept);
        done = (state_q == ACCUM) &&
               ((accept && (n_samp_d == WIN)) || (flush_w && (n_samp_d != '0)));
    end

    // Scan upward with strict '>' so the lowest index keeps an equal maximum.
    always_comb begin
        best_cls = 2'd0;
        best_cnt = cnt_d[0];
        best_tie = 1'b0;
        for (int i = 1; i < 4; i++) begin
            if (cnt_d[i] > best_cnt) begin
                best_cls = 2'(i);
                best_cnt = cnt_d[i];
                best_tie = 1'b0;
            end else if (cnt_d[i] == best_cnt) begin
                best_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            n_samp_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_class_q <= 2'd0;
            out_count_q <= '0;
            out_tie_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
                    n_samp_q <= n_samp_d;
                    if (done) begin
                        out_class_q <= best_cls;
                        out_count_q <= best_cnt;
                        out_tie_q   <= best_tie;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        state_q     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
                        n_samp_q    <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_count = out_count_q;
    assign out_tie   = out_tie_q;

endmodule

// File: tb/tb_dtc_vote_window.sv
// Directed bench for dtc_vote_window (WINDOW=16, CNT_W=8); flush scenario only when DTC_VOTE_FLUSH_EN is defined.
module tb_dtc_vote_window;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_class;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_class;
    logic [7:0] out_count;
    logic       out_tie;
`ifdef DTC_VOTE_FLUSH_EN
    logic       flush = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // {out_valid, in_ready, out_class, out_count, out_tie}
    logic [12:0] obs;
    assign obs = {out_valid, in_ready, out_class, out_count, out_tie};

    always #5 clk = ~clk;

    dtc_vote_window #(.WINDOW(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_count (out_count),
        .out_tie   (out_tie)
`ifdef DTC_VOTE_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] cls);
        in_valid = 1'b1;
        in_class = cls;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_class = 2'd0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (obs !== {1'b0, 1'b1, 2'd0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", obs, {1'b0, 1'b1, 2'd0, 8'd0, 1'b0});
        end
    endtask

    task automatic test_full_window();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(2'd2);
            if (i == 14) begin
                n_checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_early_valid: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
                end
            end
        end
        n_checks++;
        if (obs !== {1'b1, 1'b0, 2'd2, 8'd16, 1'b0}) begin
            n_fail++;
            $display("FAIL full_window: got %h expected %h", obs, {1'b1, 1'b0, 2'd2, 8'd16, 1'b0});
        end
        tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL full_handshake: got v/r=%b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_mixed_gaps();
        logic [1:0] seq [16] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0,
                                 2'd2, 2'd1, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(seq[i]);
            if (i != 15) begin
                in_class = 2'd3;
                tick();
                if (i % 2 == 1) tick();
            end
        end
        n_checks++;
        if (obs !== {1'b1, 1'b0, 2'd1, 8'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL mixed_gaps: got %h expected %h", obs, {1'b1, 1'b0, 2'd1, 8'd6, 1'b0});
        end
        tick();
    endtask

    task automatic test_tie();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(2'd3);
        for (int i = 0; i < 8; i++) send(2'd1);
        n_checks++;
        if (obs !== {1'b1, 1'b0, 2'd1, 8'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL tie: got %h expected %h", obs, {1'b1, 1'b0, 2'd1, 8'd8, 1'b1});
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(2'd0);
        for (int i = 0; i < 6; i++) send(2'd2);
        in_valid = 1'b1;
        in_class = 2'd3;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (obs !== {1'b1, 1'b0, 2'd0, 8'd10, 1'b0}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got %h expected %h", c, obs, {1'b1, 1'b0, 2'd0, 8'd10, 1'b0});
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure_release: got v/r=%b expected 01", {out_valid, in_ready});
        end
        for (int i = 0; i < 16; i++) send(2'd3);
        n_checks++;
        if (obs !== {1'b1, 1'b0, 2'd3, 8'd16, 1'b0}) begin
            n_fail++;
            $display("FAIL backpressure_next_window: got %h expected %h", obs, {1'b1, 1'b0, 2'd3, 8'd16, 1'b0});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(2'd0);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== {1'b0, 1'b1, 2'd0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_window: got %h expected %h", obs, {1'b0, 1'b1, 2'd0, 8'd0, 1'b0});
        end
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            send(2'd0);
            if (i == 14) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_partial_kept: got out_valid=%b expected 0", out_valid);
                end
            end
        end
        n_checks++;
        if (obs !== {1'b1, 1'b0, 2'd0, 8'd16, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_then_window: got %h expected %h", obs, {1'b1, 1'b0, 2'd0, 8'd16, 1'b0});
        end
        // Pending decision must be discarded by reset.
        out_ready = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== {1'b0, 1'b1, 2'd0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_emit: got %h expected %h", obs, {1'b0, 1'b1, 2'd0, 8'd0, 1'b0});
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

`ifdef DTC_VOTE_FLUSH_EN
    task automatic test_flush();
        out_ready = 1'b1;
        send(2'd0);
        send(2'd0);
        send(2'd2);
        flush = 1'b1;
        send(2'd2);
        flush = 1'b0;
        n_checks++;
        if (obs !== {1'b1, 1'b0, 2'd0, 8'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_early: got %h expected %h", obs, {1'b1, 1'b0, 2'd0, 8'd2, 1'b1});
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_empty: got v/r=%b expected 01", {out_valid, in_ready});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_window();
        test_mixed_gaps();
        test_tie();
        test_backpressure();
        test_reset_mid();
`ifdef DTC_VOTE_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
